// File: rtl/haar_feature_sum.sv
// rtl/haar_feature_sum.sv - weighted multi-rectangle Haar feature accumulator
// Four integral-image corners per rectangle, one signed weight per rectangle, one scaled result per feature.
module haar_feature_sum #(
    parameter int W_DATA    = 18,
    parameter int W_WEIGHT  = 3,
    parameter int MAX_RECTS = 3,
    parameter int W_SCALE   = 12,
    parameter int W_DOUT    = W_DATA + 2 + W_WEIGHT + $clog2(MAX_RECTS + 1) + W_SCALE
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             din_valid,
    output logic                             din_ready,
    input  logic [W_DATA-1:0]                din_data,
    input  logic                             weight_valid,
    output logic                             weight_ready,
    input  logic [W_WEIGHT-1:0]              weight,
    input  logic                             weight_last,
    output logic                             dout_valid,
    input  logic                             dout_ready,
    output logic [W_DOUT-1:0]                dout_data,
    output logic [$clog2(MAX_RECTS+1)-1:0]   dout_nrects,
    output logic                             dout_err
);

    localparam int W_RS = W_DATA + 2;
    localparam int W_P  = W_RS + W_WEIGHT;
    localparam int W_NR = $clog2(MAX_RECTS + 1);
    localparam int W_FA = W_P + W_NR;
    localparam int W_RC = (MAX_RECTS > 1) ? $clog2(MAX_RECTS) : 1;

    typedef enum logic {
        ACC  = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [1:0]                cc;
    logic [W_RC-1:0]           rc;
    logic signed [W_RS-1:0]    rs;
    logic signed [W_FA-1:0]    fa;

    logic                      din_fire;
    logic                      close_beat;
    logic                      last_rect;
    logic                      feature_end;
    logic signed [W_RS-1:0]    d_ext;
    logic signed [W_RS-1:0]    rs_step;
    logic signed [W_P-1:0]     p;
    logic signed [W_FA-1:0]    fa_next;
    logic signed [W_DOUT-1:0]  dout_shift;
    logic [W_NR-1:0]           nrects_next;

    // The weight gate keeps the closing corner from being taken without its weight.
    assign din_ready    = ((state == ACC) || dout_ready) && ((cc != 2'd3) || weight_valid);
    assign din_fire     = din_valid && din_ready;
    assign close_beat   = din_fire && (cc == 2'd3);
    assign weight_ready = close_beat;
    assign last_rect    = (rc == W_RC'(MAX_RECTS - 1));
    assign feature_end  = close_beat && (weight_last || last_rect);
    assign dout_valid   = (state == FULL);

    always_comb begin
        d_ext = signed'(W_RS'(din_data));
        unique case (cc)
            2'd0:    rs_step = d_ext;
            2'd1:    rs_step = rs - d_ext;
            2'd2:    rs_step = rs + d_ext;
            default: rs_step = rs - d_ext;
        endcase
        p           = W_P'(rs_step) * W_P'($signed(weight));
        fa_next     = ((rc == '0) ? W_FA'(0) : fa) + W_FA'(p);
        dout_shift  = W_DOUT'(fa_next) <<< W_SCALE;
        nrects_next = W_NR'(rc) + W_NR'(1);
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ACC:  if (feature_end) state_next = FULL;
            FULL: if (dout_ready && !feature_end) state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ACC;
            cc          <= 2'd0;
            rc          <= '0;
            rs          <= '0;
            fa          <= '0;
            dout_data   <= '0;
            dout_nrects <= '0;
            dout_err    <= 1'b0;
        end else begin
            state <= state_next;
            if (din_fire) begin
                rs <= rs_step;
                if (close_beat) begin
                    cc <= 2'd0;
                    if (feature_end) begin
                        rc          <= '0;
                        fa          <= '0;
                        dout_data   <= dout_shift;
                        dout_nrects <= nrects_next;
                        dout_err    <= !weight_last;
                    end else begin
                        rc <= rc + W_RC'(1);
                        fa <= fa_next;
                    end
                end else begin
                    cc <= cc + 2'd1;
                end
            end
        end
    end

endmodule

// File: doc/haar_feature_sum.md
# haar_feature_sum

Parametrised successor to the single-rectangle weighted-sum stage in the cascade classifier datapath. It consumes a stream of integral-image corner values, four per rectangle, and reduces each rectangle to its area sum. Each rectangle sum is multiplied by a signed per-rectangle weight, and 1 to MAX_RECTS weighted rectangles are accumulated into one Haar feature value. The block sits between the integral-image window fetch and the stage threshold comparator, and emits one scaled, signed feature value per feature with a valid/ready handshake and a back-pressure-safe output register.

## Interface
- W_DATA, 18: integral-image corner width (unsigned)
- W_WEIGHT, 3: signed rectangle weight width
- MAX_RECTS, 3: maximum rectangles per feature (≥1)
- W_SCALE, 12: left-shift applied to the final sum (×2^W_SCALE)
- W_DOUT, W_DATA+2+W_WEIGHT+$clog2(MAX_RECTS+1)+W_SCALE: output width
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- din_valid  in  1  corner value valid
- din_ready  out  1  corner value accepted when valid&ready
- din_data  in  W_DATA  corner value, unsigned
- weight_valid  in  1  rectangle weight valid
- weight_ready  out  1  weight consumed when valid&ready
- weight  in  W_WEIGHT  signed rectangle weight
- weight_last  in  1  this weight belongs to the final rectangle of the feature
- dout_valid  out  1  feature result valid
- dout_ready  in  1  downstream accepts result
- dout_data  out  W_DOUT  signed scaled feature sum
- dout_nrects  out  $clog2(MAX_RECTS+1)  rectangles accumulated into dout_data
- dout_err  out  1  feature truncated at MAX_RECTS without weight_last

## Operation
- Corner counter cc (0..3) and rectangle counter rc (0..MAX_RECTS-1).
- Rectangle sum rs is signed, W_DATA+2 bits. The sign pattern is fixed by cc: cc0 loads +d, cc1 applies −d, cc2 applies +d, cc3 applies −d.
- cc3 is the closing beat. It requires din_valid and weight_valid together, and weight is consumed only on this beat (weight_ready = din_valid & din_ready & cc==3).
- On the closing beat, the product p = rs_final × weight is formed combinationally, signed, W_DATA+2+W_WEIGHT bits.
  - Feature accumulator fa loads p when rc==0, otherwise takes fa+p.
  - fa is sign-extended to full width; no saturation, because the widths are sized for no overflow.
- The feature ends on the closing beat when weight_last=1, or when rc==MAX_RECTS-1. At feature end:
  - the output register loads dout_data = (fa+p) <<< W_SCALE, dout_nrects = rc+1, dout_err = (weight_last==0);
  - rc, cc and fa are cleared.
- Otherwise the closing beat increments rc and wraps cc to 0.
- FSM:
  - ACC: accumulating, output empty.
  - FULL: output register valid.
  - ACC→FULL on feature end.
  - FULL→ACC on dout_ready with no simultaneous feature end.
  - FULL→FULL on dout_ready together with a simultaneous feature end; the new result is loaded in the same cycle.
- din_ready = (state==ACC | dout_ready) & (cc!=3 | weight_valid).
- A weight presented while cc!=3 is held; weight_ready stays 0.

## Timing
- Reset values: din_ready=1 (cc=0 so the weight gate is open; state=ACC), weight_ready=0, dout_valid=0, dout_data=0, dout_nrects=0, dout_err=0. cc=rc=fa=0, state=ACC.
- Reset mid-feature discards all partial sums and any held output; the next accepted corner is cc0 of a new feature.
- Throughput: one corner per cycle, no bubbles while dout_ready=1.
- Latency: dout_valid rises 1 cycle after the accepted closing beat of the last rectangle.
- dout_data, dout_nrects and dout_err are stable while dout_valid & !dout_ready.
- dout_valid is a registered output; it is never combinationally dependent on din.
- A beat with din_valid=0 changes no state.
- A cc3 beat with din_valid=1 & weight_valid=0 is stalled, with din_ready=0.
- Back-to-back features: a closing beat in the cycle dout_ready=1 with FULL is accepted, giving zero dead cycles between results.

## Test plan
- Single rect, W_SCALE=12: corners 100,40,20,70, weight −1, last=1. Expected: dout_data=−40960, nrects=1, err=0, dout_valid exactly 1 cycle after the 4th corner.
- Two rects: (100,40,20,70, w=−1, last=0) then (50,10,5,20, w=2, last=1). Expected: dout_data=40<<12=163840, nrects=2.
- Truncation with MAX_RECTS=3: three rects of corners (8,0,0,0), w=1, last=0 each. Expected: dout_data=24<<12, nrects=3, err=1; the next corner starts a fresh feature.
- Backpressure: hold dout_ready=0 while a second feature arrives. Expected: din_ready drops; the first result holds stable; both results delivered in order when dout_ready=1, with no loss and no duplication.
- Weight starvation: weight_valid=0 at cc3 for 5 cycles. Expected: din_ready=0 and no state change; the result is correct after the weight arrives.
- Reset after 2 corners, then a full single-rect feature (10,0,0,0, w=1). Expected: dout_data=10<<12, dout_valid=0 during and immediately after reset.
